// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: shared types and decode helpers
// for the iterative RISC-V M-extension unit.
package riscv_mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } mdu_state_t;

    function automatic logic is_signed_a(
        input mdu_op_t op
    );
        return op inside {OP_MULH, OP_MULHSU,
                          OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_b(
        input mdu_op_t op
    );
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_div(
        input mdu_op_t op
    );
        return op[2];
    endfunction

endpackage

// File: rtl/riscv_mdu.sv
// riscv_mdu: shift-add multiplier and restoring divider,
// one bit per cycle, with a 2-cycle path for div corner cases.
module riscv_mdu
    import riscv_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    mdu_state_t        state;
    mdu_op_t           op;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   mcand;
    logic              neg_q;
    logic              neg_r;
    logic              fast;

    mdu_op_t         req_op;
    logic            sa, sb;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            b_zero, ovf, req_fast;
    logic [XLEN-1:0] fast_val;

    always_comb begin
        req_op = mdu_op_t'(funct3);
        sa     = is_signed_a(req_op) & a[XLEN-1];
        sb     = is_signed_b(req_op) & b[XLEN-1];
        abs_a  = sa ? -a : a;
        abs_b  = sb ? -b : b;
        b_zero = (b == '0);
        ovf    = (req_op inside {OP_DIV, OP_REM})
               && (a == {1'b1, {(XLEN-1){1'b0}}})
               && (b == '1);
        req_fast = is_div(req_op) & (b_zero | ovf);
        fast_val = '0;
        if (b_zero && !funct3[1])
            fast_val = '1;
        else if (b_zero || !funct3[1])
            fast_val = a;
    end

    logic [XLEN-1:0] mul_add;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ok;

    always_comb begin
        mul_add   = acc[0] ? mcand : '0;
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]}
                  + {1'b0, mul_add};
        div_shift = {rem, acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand};
        div_ok    = ~div_diff[XLEN];
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rmd, fix_val;

    always_comb begin
        prod    = neg_q ? -acc : acc;
        quo     = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rmd     = neg_r ? -rem : rem;
        fix_val = acc[XLEN-1:0];
        if (!fast) begin
            unique case (1'b1)
                op == OP_MUL:
                    fix_val = prod[XLEN-1:0];
                !is_div(op) && op != OP_MUL:
                    fix_val = prod[2*XLEN-1:XLEN];
                is_div(op) && !op[1]:
                    fix_val = quo;
                is_div(op) && op[1]:
                    fix_val = rmd;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            op     <= OP_MUL;
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            mcand  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            fast   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op    <= req_op;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        mcand <= abs_b;
                        rem   <= '0;
                        fast  <= req_fast;
                        busy  <= 1'b1;
                        if (req_fast) begin
                            acc   <= {{XLEN{1'b0}}, fast_val};
                            cnt   <= '0;
                            state <= S_FIX;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, abs_a};
                            cnt   <= CW'(XLEN - 1);
                            state <= S_CALC;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div(op)) begin
                            rem <= div_ok
                                 ? div_diff[XLEN-1:0]
                                 : div_shift[XLEN-1:0];
                            acc[XLEN-1:0] <=
                                {acc[XLEN-2:0], div_ok};
                        end else begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end
                        if (cnt == '0)
                            state <= S_FIX;
                        else
                            cnt <= cnt - 1'b1;
                    end
                end
                S_FIX: begin
                    busy <= 1'b0;
                    if (kill) begin
                        state <= S_IDLE;
                    end else begin
                        result <= fix_val;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mdu.sv
// tb_riscv_mdu: scoreboard bench for riscv_mdu, directed
// M-extension cases plus randomized ops against a 64-bit model.
module tb_riscv_mdu;

    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        busy;
    logic        done;
    logic [31:0] result;

    riscv_mdu #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        int          bsy;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    task automatic check(input string nm,
                         input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h",
                     nm, act, req);
        end
    endtask

    function automatic logic [31:0] ref_model(
        input logic [2:0] f,
        input logic [31:0] x,
        input logic [31:0] y);
        longint            sx = longint'($signed(x));
        longint            sy = longint'($signed(y));
        longint unsigned   ux = {32'h0, x};
        longint unsigned   uy = {32'h0, y};
        int                xi = $signed(x);
        int                yi = $signed(y);
        logic [63:0]       p;
        logic              ov;
        ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ux * uy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin
                p = sx * longint'(uy);
                return p[63:32];
            end
            3'd3: begin p = ux * uy; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ov) return x;
                return xi / yi;
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ov) return 32'h0;
                return xi % yi;
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic logic is_fast(
        input logic [2:0] f,
        input logic [31:0] x,
        input logic [31:0] y);
        return f[2] && (y == 0 || (!f[0]
            && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f,
                         input logic [31:0] x,
                         input logic [31:0] y,
                         input string nm);
        exp_t e;
        int   t = 0;
        logic fs;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({nm, " wait_idle"}, busy, 0);
        fs     = is_fast(f, x, y);
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        e.res  = ref_model(f, x, y);
        e.cyc  = cyc + 1 + (fs ? 1 : XLEN + 1);
        e.bsy  = fs ? 1 : XLEN + 1;
        e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset) begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    check({e.name, " result"}, result, e.res);
                    check({e.name, " done_cycle"}, cyc, e.cyc);
                    check({e.name, " busy_cycles"},
                          busy_cnt, e.bsy);
                end
                busy_cnt = 0;
            end else if (!busy) begin
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int t;
        reset  = 1'b1;
        start  = 1'b0;
        kill   = 1'b0;
        funct3 = 3'd0;
        a      = '0;
        b      = '0;
        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        reset = 1'b0;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, "MUL");
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULH");
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, "MULHSU");
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV");
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, "REM");
        issue(3'd7, 32'd100, 32'd7, "REMU");
        issue(3'd5, 32'd5, 32'd0, "DIVU_by0");
        issue(3'd6, 32'd5, 32'd0, "REM_by0");
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV_ovf");
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM_ovf");

        issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF1, "MUL_busy");
        repeat (5) @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        a      = 32'd1;
        b      = 32'd0;
        @(negedge clk);
        start = 1'b0;

        issue(3'd5, 32'd100, 32'd7, "DIVU");
        issue(3'd0, 32'd9, 32'd9, "MUL_killed");
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill busy", busy, 0);
        check("kill done", done, 0);
        check("kill result", result, 32'd14);
        void'(sb.pop_back());
        repeat (4) @(negedge clk);
        check("kill idle_result", result, 32'd14);
        issue(3'd4, 32'd1000, 32'hFFFF_FFF6, "DIV_after_kill");

        issue(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, "MULH_reset");
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset busy", busy, 0);
        check("async_reset done", done, 0);
        check("async_reset result", result, 0);
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        issue(3'd7, 32'd12345, 32'd100, "REMU_after_reset");

        for (int i = 0; i < 150; i++) begin
            logic [2:0]  rf;
            logic [31:0] rx, ry;
            rf = 3'($urandom_range(0, 7));
            rx = pick();
            ry = pick();
            issue(rf, rx, ry, $sformatf("rand%0d_f%0d", i, rf));
        end

        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
